// File: rtl/axi_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : axi_capture_ctrl
// Brief    : Single-shot AXI4 transaction capture sequencer with stall watchdog
// Revision : 1.0 - initial release
// ============================================================================
module axi_capture_ctrl #(
    parameter int ID_W        = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic            ACLK,
    input  logic            ARESETN,
    input  logic            AWVALID,
    input  logic            AWREADY,
    input  logic [31:0]     AWADDR,
    input  logic [7:0]      AWLEN,
    input  logic [2:0]      AWSIZE,
    input  logic [1:0]      AWBURST,
    input  logic [ID_W-1:0] AWID,
    input  logic            WVALID,
    input  logic            WREADY,
    input  logic            WLAST,
    input  logic [63:0]     WDATA,
    input  logic [7:0]      WSTRB,
    input  logic            BVALID,
    input  logic            BREADY,
    input  logic [ID_W-1:0] BID,
    input  logic [1:0]      BRESP,
    input  logic            ARVALID,
    input  logic            ARREADY,
    input  logic [31:0]     ARADDR,
    input  logic [7:0]      ARLEN,
    input  logic [2:0]      ARSIZE,
    input  logic [1:0]      ARBURST,
    input  logic [ID_W-1:0] ARID,
    input  logic            RVALID,
    input  logic            RREADY,
    input  logic            RLAST,
    input  logic [63:0]     RDATA,
    input  logic [ID_W-1:0] RID,
    input  logic [1:0]      RRESP,
    input  logic            Arm,
    input  logic [1:0]      Mode,
    input  logic            Abort,
    output logic [31:0]     AW,
    output logic [31:0]     AWInfo,
    output logic [63:0]     W,
    output logic [31:0]     WInfo,
    output logic [31:0]     BInfo,
    output logic [31:0]     AR,
    output logic [31:0]     ARInfo,
    output logic [63:0]     R,
    output logic [31:0]     RInfo,
    output logic            Capt,
    output logic            Busy,
    output logic            TimedOut
);

    localparam int WD_W = $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] C_WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMED  = 3'd1,
        S_W_DATA = 3'd2,
        S_W_RESP = 3'd3,
        S_R_DATA = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [WD_W-1:0] r_wdog;
    logic [7:0]      r_beat;
    logic [31:0]     r_aw, r_awinfo, r_winfo, r_binfo, r_ar, r_arinfo, r_rinfo;
    logic [63:0]     r_w, r_r;
    logic            r_capt, r_tmo;

    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic w_bid_match, w_rid_match, w_len_mism, w_in_data;
    logic [7:0] w_beat_nx;
    logic w_lat_aw, w_lat_ar, w_lat_w_first, w_lat_w_last, w_lat_b;
    logic w_lat_r_first, w_lat_r_last, w_beat_clr, w_beat_inc, w_done, w_tmo;

    assign w_aw_hs = AWVALID & AWREADY;
    assign w_w_hs  = WVALID & WREADY;
    assign w_b_hs  = BVALID & BREADY;
    assign w_ar_hs = ARVALID & ARREADY;
    assign w_r_hs  = RVALID & RREADY;

    // The captured request IDs live in the upper half of the info words.
    assign w_bid_match = (16'(BID) == r_awinfo[31:16]);
    assign w_rid_match = (16'(RID) == r_arinfo[31:16]);
    assign w_beat_nx   = (r_beat == 8'hFF) ? 8'hFF : r_beat + 8'd1;
    assign w_len_mism  = ({1'b0, w_beat_nx} != ({1'b0, r_awinfo[7:0]} + 9'd1));
    assign w_in_data   = (r_state == S_W_DATA) || (r_state == S_W_RESP) || (r_state == S_R_DATA);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= S_IDLE;
            r_wdog  <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_state_nx != r_state)
                r_wdog <= '0;
            else if (w_in_data)
                r_wdog <= r_wdog + 1'b1;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_lat_aw      = 1'b0;
        w_lat_ar      = 1'b0;
        w_lat_w_first = 1'b0;
        w_lat_w_last  = 1'b0;
        w_lat_b       = 1'b0;
        w_lat_r_first = 1'b0;
        w_lat_r_last  = 1'b0;
        w_beat_clr    = 1'b0;
        w_beat_inc    = 1'b0;
        w_done        = 1'b0;
        w_tmo         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Arm)
                    w_state_nx = S_ARMED;
            end
            S_ARMED: begin
                // Write wins when both address channels qualify together.
                if (w_aw_hs && (Mode != 2'd1)) begin
                    w_lat_aw   = 1'b1;
                    w_beat_clr = 1'b1;
                    w_state_nx = S_W_DATA;
                end else if (w_ar_hs && (Mode != 2'd0)) begin
                    w_lat_ar   = 1'b1;
                    w_beat_clr = 1'b1;
                    w_state_nx = S_R_DATA;
                end
            end
            S_W_DATA: begin
                if (w_w_hs) begin
                    w_beat_inc    = 1'b1;
                    w_lat_w_first = (r_beat == 8'd0);
                    if (WLAST) begin
                        w_lat_w_last = 1'b1;
                        w_state_nx   = S_W_RESP;
                    end
                end
            end
            S_W_RESP: begin
                if (w_b_hs && w_bid_match) begin
                    w_lat_b    = 1'b1;
                    w_done     = 1'b1;
                    w_state_nx = S_IDLE;
                end
            end
            S_R_DATA: begin
                if (w_r_hs && w_rid_match) begin
                    w_beat_inc    = 1'b1;
                    w_lat_r_first = (r_beat == 8'd0);
                    if (RLAST) begin
                        w_lat_r_last = 1'b1;
                        w_done       = 1'b1;
                        w_state_nx   = S_IDLE;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase

        // Completion on the expiry cycle is honoured; otherwise the watchdog fires.
        if (w_in_data && (w_state_nx == r_state) && (r_wdog == C_WD_LAST)) begin
            w_tmo      = 1'b1;
            w_state_nx = S_IDLE;
        end

        // Abort overrides everything, including latching on a completing handshake.
        if (Abort) begin
            w_state_nx    = S_IDLE;
            w_lat_aw      = 1'b0;
            w_lat_ar      = 1'b0;
            w_lat_w_first = 1'b0;
            w_lat_w_last  = 1'b0;
            w_lat_b       = 1'b0;
            w_lat_r_first = 1'b0;
            w_lat_r_last  = 1'b0;
            w_beat_clr    = 1'b0;
            w_beat_inc    = 1'b0;
            w_done        = 1'b0;
            w_tmo         = 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_aw     <= '0;
            r_awinfo <= '0;
            r_w      <= '0;
            r_winfo  <= '0;
            r_binfo  <= '0;
            r_ar     <= '0;
            r_arinfo <= '0;
            r_r      <= '0;
            r_rinfo  <= '0;
            r_beat   <= '0;
            r_capt   <= 1'b0;
            r_tmo    <= 1'b0;
        end else begin
            if (w_lat_aw) begin
                r_aw     <= AWADDR;
                r_awinfo <= {16'(AWID), 2'b00, AWBURST, 1'b0, AWSIZE, AWLEN};
            end
            if (w_lat_ar) begin
                r_ar     <= ARADDR;
                r_arinfo <= {16'(ARID), 2'b00, ARBURST, 1'b0, ARSIZE, ARLEN};
            end
            if (w_beat_clr)
                r_beat <= '0;
            else if (w_beat_inc)
                r_beat <= w_beat_nx;
            if (w_lat_w_first) begin
                r_w     <= WDATA;
                r_winfo <= {23'd0, WLAST, WSTRB};
            end
            // A single-beat burst takes both the first-beat and last-beat fields.
            if (w_lat_w_last)
                r_winfo[24:16] <= {w_len_mism, w_beat_nx};
            if (w_lat_b)
                r_binfo <= {16'(BID), 14'd0, BRESP};
            if (w_lat_r_first)
                r_r <= RDATA;
            if (w_lat_r_last)
                r_rinfo <= {16'(RID), 13'd0, RRESP, RLAST};
            r_capt <= w_done;
            r_tmo  <= w_tmo;
        end
    end

    assign AW       = r_aw;
    assign AWInfo   = r_awinfo;
    assign W        = r_w;
    assign WInfo    = r_winfo;
    assign BInfo    = r_binfo;
    assign AR       = r_ar;
    assign ARInfo   = r_arinfo;
    assign R        = r_r;
    assign RInfo    = r_rinfo;
    assign Capt     = r_capt;
    assign TimedOut = r_tmo;
    assign Busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire
